// File: rtl/down_timer_pkg.sv
// Shared definitions for the down-counting timer: state encodings and default widths.
package down_timer_pkg;

  // Default widths of the count value and the prescale value.
  localparam int DT_WIDTH_DEF = 8;
  localparam int DT_PRE_W_DEF = 4;

  // Controller states. Encoding 2'd3 is never entered and is treated as IDLE.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } dt_state_t;

endpackage

// File: rtl/down_timer_tick_gen.sv
// Reloadable prescale down-counter. It emits one tick every (period+1) enabled cycles.
// The period is captured on load and reused at every wrap.
module tick_gen #(
  parameter int PRE_W = 4
) (
  input  logic             clk,
  input  logic             res,
  input  logic             load,
  input  logic [PRE_W-1:0] load_val,
  input  logic             enable,
  output logic             tick
);

  localparam logic [PRE_W-1:0] ONE = {{(PRE_W-1){1'b0}}, 1'b1};

  logic [PRE_W-1:0] cnt_q, cnt_d;
  logic [PRE_W-1:0] period_q, period_d;

  // A tick happens only on enabled cycles, when the counter has reached zero.
  assign tick = enable && (cnt_q == '0);

  // Next-count logic: load wins, otherwise count down and wrap to the period on a tick.
  always_comb begin
    cnt_d    = cnt_q;
    period_d = period_q;
    if (load) begin
      cnt_d    = load_val;
      period_d = load_val;
    end else if (enable) begin
      if (cnt_q == '0) begin
        cnt_d = period_q;
      end else begin
        cnt_d = cnt_q - ONE;
      end
    end
  end

  // Counter and period registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (res) begin
      cnt_q    <= '0;
      period_q <= '0;
    end else begin
      cnt_q    <= cnt_d;
      period_q <= period_d;
    end
  end

endmodule

// File: rtl/down_timer.sv
// Loadable down-counting timer with a prescaler, one-shot or periodic (auto-reload) mode.
// It gives a registered terminal-count pulse and a done level for one-shot runs.
module down_timer
  import down_timer_pkg::*;
#(
  parameter int WIDTH = DT_WIDTH_DEF,
  parameter int PRE_W = DT_PRE_W_DEF
) (
  input  logic             clk,
  input  logic             res,
  input  logic             start,
  input  logic             stop,
  input  logic [WIDTH-1:0] load_val,
  input  logic [PRE_W-1:0] prescale,
  input  logic             periodic,
  output logic [WIDTH-1:0] y,
  output logic             busy,
  output logic             tc,
  output logic             done
);

  localparam logic [WIDTH-1:0] Y_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  dt_state_t        state_q, state_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             periodic_q, periodic_d;
  logic             tc_q, tc_d;
  logic             done_q, done_d;

  logic             start_ok;
  logic             pre_en;
  logic             tick;

  // stop has priority over start, so a start is accepted only without stop.
  assign start_ok = start && !stop;
  // The prescaler runs only during an undisturbed RUN cycle and is frozen otherwise.
  assign pre_en   = (state_q == ST_RUN) && !stop && !start;

  tick_gen #(
    .PRE_W (PRE_W)
  ) u_tick_gen (
    .clk      (clk),
    .res      (res),
    .load     (start_ok),
    .load_val (prescale),
    .enable   (pre_en),
    .tick     (tick)
  );

  // Next-state logic: stop > start > tick. At terminal count, reload or finish.
  always_comb begin
    state_d    = state_q;
    y_d        = y_q;
    reload_d   = reload_q;
    periodic_d = periodic_q;
    tc_d       = 1'b0;
    done_d     = done_q;
    if (stop) begin
      if (state_q != ST_IDLE) begin
        state_d = ST_IDLE;
        done_d  = 1'b0;
      end
    end else if (start) begin
      state_d    = ST_RUN;
      y_d        = load_val;
      reload_d   = load_val;
      periodic_d = periodic;
      done_d     = 1'b0;
    end else if (state_q == ST_RUN) begin
      if (tick) begin
        if (y_q != '0) begin
          y_d = y_q - Y_ONE;
        end else begin
          tc_d = 1'b1;
          if (periodic_q) begin
            y_d = reload_q;
          end else begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end
        end
      end
    end else if (state_q != ST_DONE) begin
      // Any unused encoding falls back to IDLE.
      state_d = ST_IDLE;
    end
  end

  // State, count, latches and registered flags with synchronous reset.
  always_ff @(posedge clk) begin
    if (res) begin
      state_q    <= ST_IDLE;
      y_q        <= '0;
      reload_q   <= '0;
      periodic_q <= 1'b0;
      tc_q       <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      y_q        <= y_d;
      reload_q   <= reload_d;
      periodic_q <= periodic_d;
      tc_q       <= tc_d;
      done_q     <= done_d;
    end
  end

  assign y    = y_q;
  assign busy = (state_q == ST_RUN);
  assign tc   = tc_q;
  assign done = done_q;

endmodule

// File: tb/tb_down_timer.sv
// Scoreboard bench for down_timer. The driver computes the expected outputs after every
// clock edge from elapsed-time arithmetic and queues them. A negedge monitor pops each
// entry and compares it with the DUT outputs.
module tb_down_timer;

  logic       clk = 1'b0;
  logic       res = 1'b1;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic [7:0] load_val = 8'd0;
  logic [3:0] prescale = 4'd0;
  logic       periodic = 1'b0;
  logic [7:0] y;
  logic       busy;
  logic       tc;
  logic       done;

  down_timer #(.WIDTH(8), .PRE_W(4)) dut (
    .clk      (clk),
    .res      (res),
    .start    (start),
    .stop     (stop),
    .load_val (load_val),
    .prescale (prescale),
    .periodic (periodic),
    .y        (y),
    .busy     (busy),
    .tc       (tc),
    .done     (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int y;
    bit busy;
    bit tc;
    bit done;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model: a run is described by the latched L, P, mode and the elapsed
  // cycle count e since the count was loaded (e=0 on the cycle y first shows L).
  bit m_active = 1'b0;
  int m_e = 0;
  int m_l = 0;
  int m_p = 0;
  bit m_per = 1'b0;
  int m_y_idle = 0;

  function automatic int period_len();
    return (m_l + 1) * (m_p + 1);
  endfunction

  function automatic int run_y();
    int t;
    t = period_len();
    if (m_per) return m_l - (m_e % t) / (m_p + 1);
    if (m_e >= t) return 0;
    return m_l - m_e / (m_p + 1);
  endfunction

  function automatic exp_t model_out();
    exp_t r;
    int t;
    t = period_len();
    if (!m_active) begin
      r.y = m_y_idle; r.busy = 1'b0; r.tc = 1'b0; r.done = 1'b0;
    end else begin
      r.y    = run_y();
      r.busy = m_per || (m_e < t);
      r.tc   = m_per ? ((m_e >= t) && (m_e % t == 0)) : (m_e == t);
      r.done = !m_per && (m_e >= t);
    end
    return r;
  endfunction

  task automatic model_step(input bit r, input bit s, input bit p, input int lv,
                            input int pv, input bit per);
    if (r) begin
      m_active = 1'b0; m_y_idle = 0;
    end else if (p) begin
      if (m_active) begin
        m_y_idle = run_y();
        m_active = 1'b0;
      end
    end else if (s) begin
      m_active = 1'b1; m_e = 0; m_l = lv; m_p = pv; m_per = per;
    end else if (m_active) begin
      m_e++;
      if (!m_per && m_e > period_len() + 1) m_e = period_len() + 1;
    end
  endtask

  // Drive one cycle of inputs, advance the model across the edge, queue the expectation.
  task automatic drive(input bit r, input bit s, input bit p, input logic [7:0] lv,
                       input logic [3:0] pv, input bit per);
    res = r; start = s; stop = p; load_val = lv; prescale = pv; periodic = per;
    @(posedge clk);
    if (s && !p && !r)
      $display("start L=%0d P=%0d periodic=%0d at %0t", lv, pv, per, $time);
    model_step(r, s, p, int'(lv), int'(pv), per);
    exp_q.push_back(model_out());
    #1;
  endtask

  // Idle cycles with random data inputs, which must not affect a run.
  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      drive(1'b0, 1'b0, 1'b0, 8'($urandom), 4'($urandom), 1'($urandom));
  endtask

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, req);
    end
  endtask

  // Monitor: compare every queued expectation against the DUT away from the edge.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("y",    int'(y),    e.y);
      check("busy", int'(busy), int'(e.busy));
      check("tc",   int'(tc),   int'(e.tc));
      check("done", int'(done), int'(e.done));
    end
  end

  initial begin
    // Power-up reset.
    drive(1'b1, 1'b0, 1'b0, 8'd0, 4'd0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 8'd0, 4'd0, 1'b0);
    // Reset during a run.
    drive(1'b0, 1'b1, 1'b0, 8'd5, 4'd0, 1'b0);
    idle(2);
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, 1'b0, 8'd7, 4'd1, 1'b1);
    idle(2);
    // One-shot L=3, P=0.
    drive(1'b0, 1'b1, 1'b0, 8'd3, 4'd0, 1'b0);
    idle(8);
    // Periodic L=2, P=1.
    drive(1'b0, 1'b1, 1'b0, 8'd2, 4'd1, 1'b1);
    idle(14);
    drive(1'b0, 1'b0, 1'b1, 8'd0, 4'd0, 1'b0);
    // Stop at y=4, then start+stop together.
    drive(1'b0, 1'b1, 1'b0, 8'd10, 4'd0, 1'b0);
    idle(6);
    drive(1'b0, 1'b0, 1'b1, 8'd0, 4'd0, 1'b0);
    idle(3);
    drive(1'b0, 1'b1, 1'b1, 8'd9, 4'd0, 1'b0);
    idle(3);
    // Restart mid-run.
    drive(1'b0, 1'b1, 1'b0, 8'd8, 4'd0, 1'b0);
    idle(3);
    drive(1'b0, 1'b1, 1'b0, 8'd2, 4'd0, 1'b0);
    idle(6);
    // Edges: L=0,P=0 periodic, then L=255 one-shot.
    drive(1'b0, 1'b1, 1'b0, 8'd0, 4'd0, 1'b1);
    idle(5);
    drive(1'b0, 1'b0, 1'b1, 8'd0, 4'd0, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 8'hFF, 4'd0, 1'b0);
    idle(260);
    // Stop while DONE clears done.
    drive(1'b0, 1'b0, 1'b1, 8'd0, 4'd0, 1'b0);
    idle(2);
    // Random phase.
    for (int i = 0; i < 3000; i++) begin
      bit r, s, p, per;
      logic [7:0] lv;
      logic [3:0] pv;
      r   = ($urandom_range(0, 199) == 0);
      s   = ($urandom_range(0, 24) == 0);
      p   = ($urandom_range(0, 59) == 0);
      lv  = ($urandom_range(0, 9) == 0) ? 8'($urandom) : 8'($urandom_range(0, 12));
      pv  = 4'($urandom_range(0, 3));
      per = 1'($urandom);
      drive(r, s, p, lv, pv, per);
    end
    @(negedge clk);
    #1;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending entries, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
